// File: rtl/tx_uart.sv
// tx_uart: buffered 8N1 UART transmitter.
// Bytes written through data_wr/din are queued in a circular FIFO and sent on
// tx_out LSB first, framed by one start bit (0) and one stop bit (1).
// Queued bytes go out back-to-back, with no idle time between frames.
//
// Parameters:
//   SYSTEM_CLK - clock frequency in Hz
//   BAUDRATE   - line rate in baud
//   DEPTH      - FIFO entries (power of two, >= 2)
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-high reset
//   data_wr - one-cycle write strobe; din is enqueued unless the FIFO is full
//   din     - byte to enqueue
//   tx_out  - registered serial output, idles high
//   full    - FIFO holds DEPTH entries
//   empty   - FIFO holds no entries
//   busy    - a frame is on the line
module tx_uart #(
  parameter int SYSTEM_CLK = 100_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int DEPTH      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_wr,
  input  logic [7:0] din,
  output logic       tx_out,
  output logic       full,
  output logic       empty,
  output logic       busy
);

  localparam int CYCLES_PER_SYMBOL = (SYSTEM_CLK + BAUDRATE / 2) / BAUDRATE;
  localparam int CW = $clog2(SYSTEM_CLK);
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] SYM_LAST  = CW'(CYCLES_PER_SYMBOL - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic push;
  logic pop;
  logic sym_end;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign push    = data_wr & ~full;
  assign sym_end = (bit_cnt == '0);

  // The FIFO head is consumed only when a frame is loaded: straight from IDLE,
  // or at the end of a stop bit so the next start bit follows without a gap.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if (state == STOP && sym_end) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Bit-timing state machine. bit_cnt counts down from SYM_LAST, so every
  // state change lands exactly CYCLES_PER_SYMBOL edges after the previous one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx_out  <= 1'b1;
      busy    <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            tx_out  <= 1'b0;
            bit_cnt <= SYM_LAST;
            busy    <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (sym_end) begin
            tx_out  <= shift[0];
            bit_idx <= '0;
            bit_cnt <= SYM_LAST;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end

        DATA: begin
          if (sym_end) begin
            bit_cnt <= SYM_LAST;
            if (bit_idx == 3'd7) begin
              tx_out <= 1'b1;
              state  <= STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx_out  <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end

        STOP: begin
          if (sym_end) begin
            if (pop) begin
              shift   <= mem[rd_ptr];
              tx_out  <= 1'b0;
              bit_cnt <= SYM_LAST;
              state   <= START;
            end else begin
              tx_out <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end

        default: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_uart.sv
// Testbench for tx_uart. Two instances share one clock:
//   u_a: 1 MHz / 100 kbaud (10 clocks per symbol), 4-entry FIFO
//   u_b: 1 MHz / 115200 baud (9 clocks per symbol), 16-entry FIFO
// Every byte expected on a line is queued when written; a per-line decoder
// pops and compares each completed frame.
module tb_tx_uart;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, wr_a, tx_a, full_a, empty_a, busy_a;
  logic [7:0] din_a;
  logic       rst_b, wr_b, tx_b, full_b, empty_b, busy_b;
  logic [7:0] din_b;

  tx_uart #(
    .SYSTEM_CLK(1_000_000),
    .BAUDRATE  (100_000),
    .DEPTH     (4)
  ) u_a (
    .clk    (clk),
    .reset  (rst_a),
    .data_wr(wr_a),
    .din    (din_a),
    .tx_out (tx_a),
    .full   (full_a),
    .empty  (empty_a),
    .busy   (busy_a)
  );

  tx_uart #(
    .SYSTEM_CLK(1_000_000),
    .BAUDRATE  (115_200),
    .DEPTH     (16)
  ) u_b (
    .clk    (clk),
    .reset  (rst_b),
    .data_wr(wr_b),
    .din    (din_b),
    .tx_out (tx_b),
    .full   (full_b),
    .empty  (empty_b),
    .busy   (busy_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int b2b [2];
  byte unsigned q_a[$];
  byte unsigned q_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic line_of(input int id);
    return (id == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic rst_of(input int id);
    return (id == 0) ? rst_a : rst_b;
  endfunction

  function automatic logic busy_of(input int id);
    return (id == 0) ? busy_a : busy_b;
  endfunction

  // Decode frames on one line: each symbol must hold one level for exactly
  // cps samples; frames interrupted by reset are discarded.
  task automatic monitor(input int id, input int cps);
    logic [7:0]   b;
    logic         lv;
    bit           ok;
    bit           aborted;
    int           sym;
    int           start_c;
    int           last_end;
    byte unsigned e;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (!rst_of(id) && line_of(id) == 1'b0) begin
        ok      = 1'b1;
        aborted = 1'b0;
        b       = '0;
        start_c = cyc;
        for (int k = 0; k < 10 * cps; k++) begin
          if (k != 0) @(negedge clk);
          if (rst_of(id)) begin
            aborted = 1'b1;
            break;
          end
          sym = k / cps;
          lv  = line_of(id);
          if (sym == 0) begin
            if (lv !== 1'b0) ok = 1'b0;
          end else if (sym == 9) begin
            if (lv !== 1'b1) ok = 1'b0;
          end else if (k % cps == 0) begin
            b[sym-1] = lv;
          end else if (lv !== b[sym-1]) begin
            ok = 1'b0;
          end
        end
        if (!aborted) begin
          if (start_c == last_end + 1) b2b[id]++;
          last_end = cyc;
          check($sformatf("frame_fmt%0d", id), {31'd0, ok}, 32'd1);
          if (id == 0) begin
            if (q_a.size() == 0) begin
              check("frame_unexp0", {24'd0, b}, 32'hFFFF_FFFF);
            end else begin
              e = q_a.pop_front();
              check("frame_byte0", {24'd0, b}, {24'd0, e});
            end
          end else begin
            if (q_b.size() == 0) begin
              check("frame_unexp1", {24'd0, b}, 32'hFFFF_FFFF);
            end else begin
              e = q_b.pop_front();
              check("frame_byte1", {24'd0, b}, {24'd0, e});
            end
          end
        end
      end
    end
  endtask

  initial monitor(0, 10);
  initial monitor(1, 9);

  // Wait (bounded) for busy, then count consecutive busy samples.
  task automatic busy_run(input int id, output int n);
    int w;
    w = 0;
    n = 0;
    while (!busy_of(id) && w < 50) begin
      w++;
      @(negedge clk);
    end
    while (busy_of(id) && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    int b0;
    b2b[0] = 0;
    b2b[1] = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    wr_a  = 1'b0; wr_b  = 1'b0;
    din_a = '0;   din_b = '0;
    repeat (2) @(negedge clk);
    check("rst_tx",    tx_a,    1);
    check("rst_busy",  busy_a,  0);
    check("rst_empty", empty_a, 1);
    check("rst_full",  full_a,  0);
    check("rst_tx_b",  tx_b,    1);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // single 0x55 frame
    wr_a = 1'b1; din_a = 8'h55; q_a.push_back(8'h55);
    @(negedge clk);
    wr_a = 1'b0;
    check("wr_empty", empty_a, 0);
    check("wr_tx",    tx_a,    1);
    check("wr_busy",  busy_a,  0);
    @(negedge clk);
    check("pop_tx",    tx_a,    0);
    check("pop_busy",  busy_a,  1);
    check("pop_empty", empty_a, 1);
    busy_run(0, n);
    check("busy_len_55", n, 100);

    // back-to-back 0xA5, 0x3C
    @(negedge clk);
    b0 = b2b[0];
    wr_a = 1'b1; din_a = 8'hA5; q_a.push_back(8'hA5);
    @(negedge clk);
    din_a = 8'h3C; q_a.push_back(8'h3C);
    @(negedge clk);
    wr_a = 1'b0;
    busy_run(0, n);
    check("busy_len_b2b", n, 200);
    check("b2b_gap", b2b[0] - b0, 1);

    // overflow with DEPTH=4
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    b0 = b2b[0];
    for (int i = 1; i <= 6; i++) begin
      wr_a = 1'b1;
      din_a = 8'(i);
      if (i <= 5) q_a.push_back(8'(i));
      @(negedge clk);
      check($sformatf("ovf_full%0d", i), full_a, (i >= 5) ? 1 : 0);
      if (i == 1) check("ovf_empty1", empty_a, 0);
      if (i == 2) begin
        check("ovf_pop_tx",   tx_a,   0);
        check("ovf_pop_busy", busy_a, 1);
      end
    end
    wr_a = 1'b0;
    busy_run(0, n);
    check("busy_len_ovf", n, 496);
    check("ovf_b2b", b2b[0] - b0, 4);

    // reset during bit 3 of 0xF0 with two bytes queued
    @(negedge clk);
    wr_a = 1'b1; din_a = 8'hF0;
    @(negedge clk);
    din_a = 8'h11;
    @(negedge clk);
    din_a = 8'h22;
    @(negedge clk);
    wr_a = 1'b0;
    repeat (43) @(negedge clk);
    check("bit3_low", tx_a, 0);
    #2 rst_a = 1'b1;
    #1;
    check("arst_tx",    tx_a,    1);
    check("arst_empty", empty_a, 1);
    check("arst_busy",  busy_a,  0);
    check("arst_full",  full_a,  0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    n = 0;
    m = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1) n++;
      if (busy_a !== 1'b0) m++;
    end
    check("post_rst_tx_low", n, 0);
    check("post_rst_busy",   m, 0);

    // push and pop on the same edge at the end of a stop bit
    @(negedge clk);
    b0 = b2b[0];
    wr_a = 1'b1; din_a = 8'h81; q_a.push_back(8'h81);
    @(negedge clk);
    din_a = 8'h7E; q_a.push_back(8'h7E);
    @(negedge clk);
    wr_a = 1'b0;
    check("pp_queued", empty_a, 0);
    repeat (99) @(negedge clk);
    check("pp_stop", tx_a, 1);
    wr_a = 1'b1; din_a = 8'h42; q_a.push_back(8'h42);
    @(negedge clk);
    wr_a = 1'b0;
    check("pp_tx",    tx_a,    0);
    check("pp_busy",  busy_a,  1);
    check("pp_empty", empty_a, 0);
    check("pp_full",  full_a,  0);
    busy_run(0, n);
    check("busy_len_pp", n, 200);
    check("pp_b2b", b2b[0] - b0, 2);

    // rounding: 9 clocks per symbol
    wr_b = 1'b1; din_b = 8'h00; q_b.push_back(8'h00);
    @(negedge clk);
    wr_b = 1'b0;
    @(negedge clk);
    n = 0;
    while (tx_b === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("rnd_low_len", n, 81);
    m = 0;
    while (busy_b === 1'b1 && m < 1000) begin
      m++;
      @(negedge clk);
    end
    check("rnd_stop_len", m, 9);
    wr_b = 1'b1; din_b = 8'hC3; q_b.push_back(8'hC3);
    @(negedge clk);
    wr_b = 1'b0;
    busy_run(1, n);
    check("busy_len_rnd", n, 90);

    repeat (5) @(negedge clk);
    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_uart.md
# tx_uart

Buffered 8N1 UART transmitter, the transmit counterpart of the SoC's UART receive path. The CPU-side bus glue writes bytes into an internal FIFO. A bit-timing state machine drains the FIFO and serialises each byte onto `tx_out`: LSB first, one start bit, one stop bit, no parity. Status outputs let software poll for space and for transmission complete.

## Interface
Parameters:
- `SYSTEM_CLK`, 100_000_000: clock frequency in Hz.
- `BAUDRATE`, 9600: line rate in baud.
- `DEPTH`, 16: FIFO entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_wr`  in  1  write strobe, one cycle per byte.
- `din`  in  8  byte to enqueue; sampled when `data_wr`=1.
- `tx_out`  out  1  serial line; idles high.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `busy`  out  1  a frame is on the line (state ≠ IDLE).

## Operation
- `CYCLES_PER_SYMBOL` = (SYSTEM_CLK + BAUDRATE/2) / BAUDRATE, using integer division. The bit counter width is $clog2(SYSTEM_CLK).
- FIFO:
  - Circular buffer with read pointer, write pointer and an occupancy count of width $clog2(DEPTH)+1.
  - A push occurs when `data_wr` & ~`full`.
  - `full` is taken from the pre-edge count. A write while full is dropped silently, even if a pop occurs in the same cycle.
  - A pop occurs only inside the state machine, when a frame is loaded.
  - Count: +1 on push only, −1 on pop only, unchanged when both occur.
  - Pointers wrap modulo `DEPTH`.
- State machine:
  - IDLE: `tx_out`=1. If the FIFO is non-empty: pop the head into the shift register, drive `tx_out`=0, load the bit counter, go to START.
  - START: hold 0 for `CYCLES_PER_SYMBOL` cycles, then drive shift[0], set bit_idx=0, go to DATA.
  - DATA: each symbol period, shift right and drive the next bit. After bit 7's period, drive 1 and go to STOP.
  - STOP: hold 1 for `CYCLES_PER_SYMBOL` cycles. At the end, if the FIFO is non-empty, pop and go directly to START with `tx_out`=0 (no idle gap). Otherwise go to IDLE.
  - Any illegal state goes to IDLE.
- `tx_out` is a register output; no combinational path from inputs.
- Reset values:
  - `tx_out`=1, `busy`=0, `empty`=1, `full`=0.
  - Pointers and count = 0, state = IDLE.
- Reset asserted mid-frame:
  - `tx_out` goes high immediately (asynchronous).
  - The current frame is aborted and queued bytes are discarded.
  - After release, nothing is transmitted until the next write.

## Timing
- Each symbol lasts exactly `CYCLES_PER_SYMBOL` clocks. A frame is exactly 10×`CYCLES_PER_SYMBOL` clocks.
- A write at edge N into an empty FIFO with state IDLE:
  - `empty`=0 after edge N.
  - At edge N+1 the byte is popped, `tx_out`=0 and `busy`=1.
  - `empty` returns to 1 after edge N+1.
- `busy` deasserts at the same edge where the stop bit ends and the FIFO is empty.
- Queued bytes are transmitted back-to-back, with stop bit and next start bit adjacent.
- `full` and `empty` update on the same edge as the push or pop that changes the count.

## Test plan
- Frame content: SYSTEM_CLK=1_000_000, BAUDRATE=100_000 (CYCLES_PER_SYMBOL=10). Write 0x55 once.
  - `tx_out` sequence, each level held 10 cycles: 0,1,0,1,0,1,0,1,0,1.
  - `busy` is high for exactly 100 cycles; `tx_out` low exactly 1 cycle after the write.
- Back-to-back: write 0xA5 then 0x3C on consecutive cycles.
  - 200 contiguous busy cycles; bits decode to 0xA5, then 0x3C.
  - No high cycle between the first stop bit and the second start bit.
- Overflow: DEPTH=4, write 6 bytes 0x01..0x06 on consecutive cycles from reset.
  - 0x01 is popped at the cycle-1 edge; `full` rises after 0x05.
  - 0x06 is dropped.
  - Exactly 0x01..0x05 are transmitted, in order.
- Rounding: SYSTEM_CLK=1_000_000, BAUDRATE=115200 gives CYCLES_PER_SYMBOL=9. Write 0x00 -> start plus 8 data bits low for 81 cycles, then stop high for 9 cycles.
- Reset mid-frame: assert `reset` during bit 3 of 0xF0 with two bytes queued.
  - `tx_out`=1 without waiting for a clock edge; `empty`=1, `busy`=0.
  - No further transmission after release.
- Simultaneous push and pop: with one byte queued at the end of a stop bit, write a new byte on that same edge.
  - Count stays 1 and the next frame starts without a gap.
  - The new byte is sent after it.
